alarm_scheduler: RTL and testbench

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

---
 rtl/alarm_scheduler.sv | 160 ++++++++++++++++
 tb/tb_alarm_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: stores the alarm time and runs the arm/ring/snooze/stop
// controller. Buttons are active-low and act on their falling sample.
module alarm_scheduler #(
   parameter int MAX_MINUTES      = 60,
   parameter int MAX_HOURS        = 24,
   parameter int SNOOZE_MIN       = 5,
   parameter int RING_TIMEOUT_MIN = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [$clog2(MAX_MINUTES)-1:0] cur_minutes,
   input  logic [$clog2(MAX_HOURS)-1:0]   cur_hours,
   input  logic                           minute_tick,
   input  logic                           set_alarm,
   input  logic [$clog2(MAX_MINUTES)-1:0] new_alarm_minutes,
   input  logic [$clog2(MAX_HOURS)-1:0]   new_alarm_hours,
   input  logic                           alarm_enable,
   input  logic                           stop_btn,
   input  logic                           snooze_btn,
   output logic [$clog2(MAX_MINUTES)-1:0] alarm_minutes,
   output logic [$clog2(MAX_HOURS)-1:0]   alarm_hours,
   output logic                           ringing,
   output logic                           snooze_active,
   output logic [1:0]                     state
);

   localparam int MW = $clog2(MAX_MINUTES);
   localparam int HW = $clog2(MAX_HOURS);

   localparam logic [MW:0] MIN_LIM  = (MW+1)'(MAX_MINUTES);
   localparam logic [HW:0] HOUR_LIM = (HW+1)'(MAX_HOURS);
   localparam logic [3:0]  SNZ_LEN  = 4'(SNOOZE_MIN);
   localparam logic [3:0]  RTO_LAST = 4'(RING_TIMEOUT_MIN - 1);

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZE   = 2'd3
   } state_t;

   state_t     st;
   logic [3:0] ring_cnt;
   logic [3:0] snooze_cnt;
   logic       stop_q;
   logic       snooze_q;
   logic       stop_press;
   logic       snooze_press;
   logic       load_ok;
   logic       hit;

   assign state        = st;
   assign stop_press   = stop_q & ~stop_btn;
   assign snooze_press = snooze_q & ~snooze_btn;

   // Out-of-range load requests are dropped entirely.
   assign load_ok = set_alarm
                  && ({1'b0, new_alarm_minutes} < MIN_LIM)
                  && ({1'b0, new_alarm_hours} < HOUR_LIM);

   // Trigger only on the tick that lands on the stored time.
   assign hit = minute_tick
              && (cur_hours == alarm_hours)
              && (cur_minutes == alarm_minutes);

   // Button history; idles high so a press is a 1 -> 0 sample pair.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stop_q   <= 1'b1;
         snooze_q <= 1'b1;
      end else begin
         stop_q   <= stop_btn;
         snooze_q <= snooze_btn;
      end
   end

   // Alarm registers and controller with registered state decodes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st            <= DISARMED;
         ringing       <= 1'b0;
         snooze_active <= 1'b0;
         alarm_minutes <= '0;
         alarm_hours   <= '0;
         ring_cnt      <= '0;
         snooze_cnt    <= '0;
      end else begin
         if (load_ok) begin
            alarm_minutes <= new_alarm_minutes;
            alarm_hours   <= new_alarm_hours;
         end
         if (!alarm_enable) begin
            st            <= DISARMED;
            ringing       <= 1'b0;
            snooze_active <= 1'b0;
            ring_cnt      <= '0;
            snooze_cnt    <= '0;
         end else if (load_ok || st == DISARMED) begin
            st            <= ARMED;
            ringing       <= 1'b0;
            snooze_active <= 1'b0;
            ring_cnt      <= '0;
            snooze_cnt    <= '0;
         end else begin
            unique case (st)
               ARMED: begin
                  if (hit) begin
                     st       <= RINGING;
                     ringing  <= 1'b1;
                     ring_cnt <= '0;
                  end
               end
               RINGING: begin
                  if (stop_press) begin
                     st         <= ARMED;
                     ringing    <= 1'b0;
                     ring_cnt   <= '0;
                     snooze_cnt <= '0;
                  end else if (snooze_press) begin
                     st            <= SNOOZE;
                     ringing       <= 1'b0;
                     snooze_active <= 1'b1;
                     snooze_cnt    <= SNZ_LEN;
                  end else if (minute_tick) begin
                     if (ring_cnt == RTO_LAST) begin
                        st         <= ARMED;
                        ringing    <= 1'b0;
                        ring_cnt   <= '0;
                        snooze_cnt <= '0;
                     end else if (ring_cnt != 4'hf) begin
                        ring_cnt <= ring_cnt + 4'd1;
                     end
                  end
               end
               SNOOZE: begin
                  if (stop_press) begin
                     st            <= ARMED;
                     snooze_active <= 1'b0;
                     ring_cnt      <= '0;
                     snooze_cnt    <= '0;
                  end else if (minute_tick) begin
                     if (snooze_cnt <= 4'd1) begin
                        st            <= RINGING;
                        ringing       <= 1'b1;
                        snooze_active <= 1'b0;
                        ring_cnt      <= '0;
                     end else begin
                        snooze_cnt <= snooze_cnt - 4'd1;
                     end
                  end
               end
               default: begin
                  st <= DISARMED;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: directed and random stimulus for alarm_scheduler,
// checked against an event-level model of the alarm clock behaviour.
module tb_alarm_scheduler;

   localparam int S_DIS  = 0;
   localparam int S_ARM  = 1;
   localparam int S_RING = 2;
   localparam int S_SNZ  = 3;
   localparam int SNZ    = 5;
   localparam int RTO    = 10;

   logic       clk;
   logic       rst;
   logic [5:0] cur_m;
   logic [4:0] cur_h;
   logic       minute_tick;
   logic       set_alarm;
   logic [5:0] new_m;
   logic [4:0] new_h;
   logic       alarm_enable;
   logic       stop_btn;
   logic       snooze_btn;
   logic [5:0] alarm_minutes;
   logic [4:0] alarm_hours;
   logic       ringing;
   logic       snooze_active;
   logic [1:0] state;

   int n_tests;
   int n_fail;

   int         m_st;
   int         m_elapsed;
   int         m_left;
   logic [5:0] m_am;
   logic [4:0] m_ah;
   bit         m_stop_h;
   bit         m_snz_h;

   alarm_scheduler dut (
      .clk               (clk),
      .rst               (rst),
      .cur_minutes       (cur_m),
      .cur_hours         (cur_h),
      .minute_tick       (minute_tick),
      .set_alarm         (set_alarm),
      .new_alarm_minutes (new_m),
      .new_alarm_hours   (new_h),
      .alarm_enable      (alarm_enable),
      .stop_btn          (stop_btn),
      .snooze_btn        (snooze_btn),
      .alarm_minutes     (alarm_minutes),
      .alarm_hours       (alarm_hours),
      .ringing           (ringing),
      .snooze_active     (snooze_active),
      .state             (state)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st      = S_DIS;
      m_elapsed = 0;
      m_left    = 0;
      m_am      = '0;
      m_ah      = '0;
      m_stop_h  = 1'b1;
      m_snz_h   = 1'b1;
   endtask

   // One clock edge of the alarm clock, expressed as events in priority order.
   task automatic model_edge();
      bit sp;
      bit zp;
      bit ld;
      sp = m_stop_h && !stop_btn;
      zp = m_snz_h && !snooze_btn;
      m_stop_h = stop_btn;
      m_snz_h  = snooze_btn;
      ld = set_alarm && (int'(new_m) < 60) && (int'(new_h) < 24);
      if (!alarm_enable) begin
         m_st = S_DIS;
      end else if (ld || m_st == S_DIS) begin
         m_st = S_ARM;
      end else if (m_st == S_ARM) begin
         if (minute_tick && cur_m == m_am && cur_h == m_ah) begin
            m_st = S_RING;
            m_elapsed = 0;
         end
      end else if (m_st == S_RING) begin
         if (sp) m_st = S_ARM;
         else if (zp) begin
            m_st = S_SNZ;
            m_left = SNZ;
         end else if (minute_tick) begin
            m_elapsed++;
            if (m_elapsed >= RTO) m_st = S_ARM;
         end
      end else begin
         if (sp) m_st = S_ARM;
         else if (minute_tick) begin
            m_left--;
            if (m_left <= 0) begin
               m_st = S_RING;
               m_elapsed = 0;
            end
         end
      end
      if (ld) begin
         m_am = new_m;
         m_ah = new_h;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"}, 32'(state), 32'(m_st));
      chk({tag, ".ringing"}, 32'(ringing), 32'(m_st == S_RING));
      chk({tag, ".snooze"}, 32'(snooze_active), 32'(m_st == S_SNZ));
      chk({tag, ".amin"}, 32'(alarm_minutes), 32'(m_am));
      chk({tag, ".ahr"}, 32'(alarm_hours), 32'(m_ah));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic tick_at(input int h, input int m, input string tag);
      cur_h = 5'(h);
      cur_m = 6'(m);
      minute_tick = 1'b1;
      step(tag);
      minute_tick = 1'b0;
   endtask

   task automatic load(input int h, input int m, input string tag);
      set_alarm = 1'b1;
      new_h = 5'(h);
      new_m = 6'(m);
      step(tag);
      set_alarm = 1'b0;
   endtask

   task automatic press_stop(input string tag);
      stop_btn = 1'b0;
      step(tag);
      stop_btn = 1'b1;
      step({tag, "_rel"});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      cur_m = '0;
      cur_h = '0;
      minute_tick = 1'b0;
      set_alarm = 1'b0;
      new_m = '0;
      new_h = '0;
      alarm_enable = 1'b0;
      stop_btn = 1'b1;
      snooze_btn = 1'b1;
      model_reset();

      #25;
      chk("rst_state", 32'(state), 0);
      chk("rst_ringing", 32'(ringing), 0);
      chk("rst_snooze", 32'(snooze_active), 0);
      chk("rst_amin", 32'(alarm_minutes), 0);
      chk("rst_ahr", 32'(alarm_hours), 0);
      #2 rst = 1'b1;

      alarm_enable = 1'b1;
      step("arm");
      chk("arm_const", 32'(state), 1);

      load(7, 30, "load_0730");
      chk("load_amin", 32'(alarm_minutes), 30);
      chk("load_ahr", 32'(alarm_hours), 7);

      for (int i = 0; i < 4; i++) begin
         int rm;
         rm = int'($urandom_range(0, 59));
         if (rm == 30) rm = 31;
         tick_at(7, rm, "miss");
         step("idle");
      end
      cur_m = 6'd30;
      cur_h = 5'd7;
      step("no_tick_match");

      tick_at(7, 30, "trigger");
      chk("trigger_state", 32'(state), 2);
      chk("trigger_ring", 32'(ringing), 1);

      snooze_btn = 1'b0;
      step("snz_press");
      snooze_btn = 1'b1;
      chk("snz_state", 32'(state), 3);
      step("snz_rel");
      for (int i = 0; i < 4; i++) begin
         tick_at(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                 "snz_tick");
         chk("snz_hold", 32'(state), 3);
         repeat ($urandom_range(0, 2)) step("snz_gap");
      end
      tick_at(7, 40, "snz_end");
      chk("snz_ring", 32'(state), 2);

      stop_btn = 1'b0;
      snooze_btn = 1'b0;
      step("both");
      chk("both_state", 32'(state), 1);
      chk("both_ring", 32'(ringing), 0);
      stop_btn = 1'b1;
      snooze_btn = 1'b1;
      step("both_rel");

      tick_at(7, 30, "retrigger");
      for (int i = 1; i < RTO; i++) begin
         tick_at(7, 30 + i, "ring_tick");
         chk("ring_hold", 32'(state), 2);
         repeat ($urandom_range(0, 2)) step("ring_gap");
      end
      tick_at(7, 40, "timeout");
      chk("timeout_state", 32'(state), 1);

      load(3, 60, "bad_min");
      chk("bad_min_amin", 32'(alarm_minutes), 30);
      load(24, 10, "bad_hr");
      chk("bad_hr_ahr", 32'(alarm_hours), 7);

      tick_at(7, 30, "ring3");
      snooze_btn = 1'b0;
      step("snz3");
      snooze_btn = 1'b1;
      step("snz3_rel");
      alarm_enable = 1'b0;
      step("disable");
      chk("disable_state", 32'(state), 0);
      alarm_enable = 1'b1;
      step("reenable");

      cur_h = 5'd12;
      cur_m = 6'd15;
      minute_tick = 1'b1;
      load(12, 15, "same_min");
      minute_tick = 1'b0;
      chk("same_min_state", 32'(state), 1);
      step("same_idle");
      tick_at(12, 16, "next_min");
      tick_at(12, 15, "recur");
      chk("recur_state", 32'(state), 2);

      #3 rst = 1'b0;
      stop_btn = 1'b0;
      #1;
      model_reset();
      chk("arst_state", 32'(state), 0);
      chk("arst_ring", 32'(ringing), 0);
      chk("arst_snz", 32'(snooze_active), 0);
      chk("arst_amin", 32'(alarm_minutes), 0);
      chk("arst_ahr", 32'(alarm_hours), 0);
      #4 rst = 1'b1;
      step("post_rst");
      chk("post_rst_state", 32'(state), 1);
      load(6, 45, "load_0645");
      tick_at(6, 45, "held_trig");
      step("held_wait");
      chk("held_state", 32'(state), 2);
      stop_btn = 1'b1;
      step("held_rel");
      chk("held_rel_state", 32'(state), 2);
      stop_btn = 1'b0;
      step("held_press");
      chk("held_press_state", 32'(state), 1);
      stop_btn = 1'b1;
      step("held_idle");

      for (int i = 0; i < 600; i++) begin
         alarm_enable = ($urandom_range(0, 31) != 0);
         set_alarm = ($urandom_range(0, 15) == 0);
         new_m = 6'($urandom_range(0, 63));
         new_h = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) stop_btn = ~stop_btn;
         if ($urandom_range(0, 3) == 0) snooze_btn = ~snooze_btn;
         minute_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 0) begin
            cur_m = m_am;
            cur_h = m_ah;
         end else begin
            cur_m = 6'($urandom_range(0, 59));
            cur_h = 5'($urandom_range(0, 23));
         end
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
